// File: rtl/riscv_pkg.sv
// Types and constants shared by the fetch stage and its neighbours.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } if_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_ILL      = 2'd1,
        CAUSE_MISALIGN = 2'd2
    } trap_cause_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction ROM port, control inputs from EX/hazard/decode,
// and the instruction presented to decode.
interface if_stage_if;
    import riscv_pkg::*;

    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ill;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        trap;
    trap_cause_t trap_cause;
    logic        halted;

    modport master (
        output imem_addr, if_instr, if_pc, if_valid, trap, trap_cause, halted,
        input  imem_rdata, stall, redirect, redirect_pc, id_ill
    );

    modport slave (
        input  imem_addr, if_instr, if_pc, if_valid, trap, trap_cause, halted,
        output imem_rdata, stall, redirect, redirect_pc, id_ill
    );

endinterface

// File: rtl/if_pc_sel.sv
// Next-PC priority mux and trap detection for the fetch stage (purely combinational).
module if_pc_sel
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
    parameter bit          HALT_ON_TRAP = 1'b0
) (
    input  if_state_t   state,
    input  logic [31:0] pc_q,
    input  logic        if_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ill,
    output logic [31:0] pc_next,
    output logic        take_trap,
    output trap_cause_t cause,
    output logic        xfer
);

    logic [31:0] trap_pc;

    // When parking in HALT the trap vector is never fetched; hold the PC instead.
    assign trap_pc = HALT_ON_TRAP ? pc_q : TRAP_VEC;

    always_comb begin
        pc_next   = pc_q;
        take_trap = 1'b0;
        cause     = CAUSE_NONE;
        xfer      = 1'b0;
        case (state)
            BOOT: pc_next = RESET_PC;
            RUN: begin
                if (redirect && (redirect_pc[1:0] != 2'b00)) begin
                    pc_next   = trap_pc;
                    take_trap = 1'b1;
                    cause     = CAUSE_MISALIGN;
                    xfer      = 1'b1;
                end else if (redirect) begin
                    pc_next = redirect_pc;
                    xfer    = 1'b1;
                end else if (id_ill && if_valid) begin
                    pc_next   = trap_pc;
                    take_trap = 1'b1;
                    cause     = CAUSE_ILL;
                    xfer      = 1'b1;
                end else if (stall || !if_valid) begin
                    // A bubble re-reads the target so its instruction follows the bubble.
                    pc_next = pc_q;
                end else begin
                    pc_next = pc_q + 32'd4;
                end
            end
            default: pc_next = pc_q;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous ROM, and hands
// fetched instructions to decode with redirect, stall and trap handling.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
    parameter bit          HALT_ON_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    if_stage_if.master bus
);

    if_state_t   state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic        valid_q;
    logic        trap_q;
    trap_cause_t cause_q;
    logic        take_trap;
    trap_cause_t cause_d;
    logic        xfer;

    if_pc_sel #(
        .RESET_PC    (RESET_PC),
        .TRAP_VEC    (TRAP_VEC),
        .HALT_ON_TRAP(HALT_ON_TRAP)
    ) u_pc_sel (
        .state      (state_q),
        .pc_q       (pc_q),
        .if_valid   (valid_q),
        .stall      (bus.stall),
        .redirect   (bus.redirect),
        .redirect_pc(bus.redirect_pc),
        .id_ill     (bus.id_ill),
        .pc_next    (pc_next),
        .take_trap  (take_trap),
        .cause      (cause_d),
        .xfer       (xfer)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            trap_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            pc_q    <= pc_next;
            trap_q  <= take_trap;
            cause_q <= cause_d;
            case (state_q)
                BOOT: begin
                    // RESET_PC was sampled by the ROM on this edge, so it is valid next cycle.
                    state_q <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: begin
                    valid_q <= !xfer;
                    if (take_trap && HALT_ON_TRAP)
                        state_q <= HALT;
                end
                default: valid_q <= 1'b0;
            endcase
        end
    end

    assign bus.imem_addr  = pc_next;
    assign bus.if_instr   = valid_q ? bus.imem_rdata : NOP_INSTR;
    assign bus.if_pc      = pc_q;
    assign bus.if_valid   = valid_q;
    assign bus.trap       = trap_q;
    assign bus.trap_cause = cause_q;
    assign bus.halted     = (state_q == HALT);

endmodule
